// File: rtl/fir_uart_pkg.sv
// Shared types and constants for the FIR-result UART transmitter.
// The helper provides the saturating increment used by the drop counter.
package fir_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_BYTES      = 2;
  localparam int DROP_CNT_W      = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fir_uart_tx_byte_tx.sv
// Single-byte UART 8N1 transmitter. A start accepted during the final stop-bit
// cycle chains the next byte with no idle gap.
module uart_byte_tx
  import fir_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_FRAME_BITS - 3);

  uart_state_t   state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    byte_reg, byte_next;
  logic          tx_reg, tx_next;
  logic          baud_last;

  assign baud_last = (baud_reg == BAUD_LAST);
  assign done      = (state_reg == STOP) && baud_last;
  assign tx        = tx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    baud_next  = (state_reg == IDLE || baud_last) ? '0 : baud_reg + 1'b1;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = START;
          byte_next  = data;
        end
      end
      START: begin
        if (baud_last) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_reg == BIT_LAST) state_next = STOP;
          else                     bit_next   = bit_reg + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (start) begin
            state_next = START;
            byte_next  = data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is computed from the upcoming state so tx leaves a flop.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = byte_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/fir_uart_tx.sv
// Sends each accepted 16-bit filter sample as two chained UART bytes, high
// byte first; samples arriving mid-transfer are dropped and counted.
module fir_uart_tx
  import fir_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           y_dat,
  input  logic                  y_vld,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  logic [15:0]           shadow_reg;
  logic                  byte_idx_reg;
  logic                  busy_reg;
  logic                  frame_done_reg;
  logic [DROP_CNT_W-1:0] drop_reg;

  logic       accept;
  logic       last_byte;
  logic       byte_start;
  logic       byte_done;
  logic [7:0] byte_data;

  assign accept     = y_vld && !busy_reg;
  assign last_byte  = (byte_idx_reg == 1'(UART_BYTES - 1));
  assign byte_start = accept || (byte_done && !last_byte);
  // The first byte bypasses the shadow, which is only written at this edge.
  assign byte_data  = accept       ? y_dat[15:8] :
                      byte_idx_reg ? shadow_reg[15:8] : shadow_reg[7:0];

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg     <= '0;
      byte_idx_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_reg       <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      if (accept) begin
        shadow_reg   <= y_dat;
        byte_idx_reg <= 1'b0;
        busy_reg     <= 1'b1;
      end else if (byte_done) begin
        if (last_byte) begin
          busy_reg       <= 1'b0;
          frame_done_reg <= 1'b1;
        end else begin
          byte_idx_reg <= 1'b1;
        end
      end
      if (y_vld && busy_reg) drop_reg <= sat_inc(drop_reg);
    end
  end

  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign drop_cnt   = drop_reg;

endmodule

// File: tb/tb_fir_uart_tx.sv
// Scoreboarded bench: stimulus queues expected frames from a timing model,
// a line monitor decodes tx and checks each frame on frame_done.
module tb_fir_uart_tx;
  import fir_uart_pkg::*;

  localparam int C     = 4;
  localparam int FRAME = UART_BYTES * UART_FRAME_BITS * C;

  typedef struct {
    logic [15:0] d;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        y_vld = 1'b0;
  logic [15:0] y_dat = '0;
  logic        tx, busy, frame_done;
  logic [7:0]  drop_cnt;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   free_at = 0;
  int   exp_drop = 0;

  fir_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .y_dat     (y_dat),
    .y_vld     (y_vld),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // One stimulus cycle; the model decides accept/drop from frame occupancy.
  task automatic drive(input logic v, input logic [15:0] d);
    @(negedge clk);
    y_vld = v;
    y_dat = d;
    if (v) begin
      if (cyc >= free_at) begin
        exp_q.push_back('{d, cyc});
        free_at = cyc + FRAME + 1;
        $display("accept k=%0d data=%h", cyc, d);
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0);
  endtask

  task automatic wait_until(input int t);
    while (cyc + 1 < t) drive(1'b0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    y_vld = 1'b0;
    rst   = 1'b1;
    exp_q.delete();
    free_at  = 0;
    exp_drop = 0;
    repeat (n) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
  endtask

  task automatic drain();
    wait_until(free_at + 3);
    chk("frames_outstanding", exp_q.size(), 0);
  endtask

  // Line monitor state
  logic bits[20];
  int   st = 0;
  bit   act = 1'b0;
  bit   glitch = 1'b0;
  bit   busy_bad = 1'b0;

  task automatic end_frame(input int rel);
    exp_t        e;
    logic [15:0] got;
    bit          framing;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_frame_done cyc=%0d got=1 want=0", cyc);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < 8; i++) begin
        got[8 + i] = bits[1 + i];
        got[i]     = bits[11 + i];
      end
      framing = (bits[0] === 1'b0) && (bits[9] === 1'b1) &&
                (bits[10] === 1'b0) && (bits[19] === 1'b1);
      if (!act || rel != FRAME || st != e.k + 1 || got !== e.d || !framing ||
          glitch || busy_bad || busy !== 1'b0 || tx !== 1'b1) begin
        n_err++;
        $display("FAIL frame k=%0d got data=%h start=%0d done=%0d framing=%0b glitch=%0b busy_bad=%0b want data=%h start=%0d done=%0d",
                 e.k, got, st, cyc, framing, glitch, busy_bad, e.d, e.k + 1, e.k + 1 + FRAME);
      end else begin
        $display("frame k=%0d data=%h done=%0d ok", e.k, got, cyc);
      end
    end
  endtask

  always @(posedge clk) begin
    int rel;
    #1;
    if (rst) begin
      act = 1'b0;
    end else begin
      if (!act && tx === 1'b0) begin
        act      = 1'b1;
        st       = cyc;
        glitch   = 1'b0;
        busy_bad = 1'b0;
      end
      rel = act ? cyc - st : 0;
      if (act && rel < FRAME) begin
        if (rel % C == 0)                  bits[rel / C] = tx;
        else if (tx !== bits[rel / C])     glitch = 1'b1;
        if (busy !== 1'b1)                 busy_bad = 1'b1;
      end
      if (frame_done === 1'b1) begin
        end_frame(rel);
        act = 1'b0;
      end else if (act && rel >= FRAME) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_timeout start=%0d got no frame_done want done=%0d", st, st + FRAME);
        act = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int k0;
    do_reset(3);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 16'h0);
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_drop", drop_cnt, 0);
    end

    drive(1'b1, 16'hA55A);
    drain();

    drive(1'b1, 16'h1234);
    k0 = cyc;
    wait_until(k0 + 10);
    drive(1'b1, 16'hBEEF);
    drive(1'b0, 16'h0);
    chk("drop_one_cycle_later", drop_cnt, exp_drop);
    wait_until(k0 + 40);
    drive(1'b1, 16'hBEEF);
    drive(1'b0, 16'h0);
    chk("drop_two", drop_cnt, exp_drop);
    drain();

    drive(1'b1, 16'h8001);
    wait_until(free_at);
    drive(1'b1, 16'h7FFE);
    drive(1'b0, 16'h0);
    chk("back_to_back_drop", drop_cnt, exp_drop);
    drain();

    drive(1'b1, 16'h5AC3);
    k0 = cyc;
    wait_until(k0 + 1 + 14 * C);
    do_reset(1);
    idle(5);
    drive(1'b1, 16'h0F0F);
    drain();

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 100));
      drive(1'b1, 16'($urandom));
      if ($urandom_range(0, 3) == 0) drive(1'b1, 16'($urandom));
    end
    drive(1'b0, 16'h0);
    chk("random_drop", drop_cnt, exp_drop);
    drain();

    repeat (300) drive(1'b1, 16'($urandom));
    drive(1'b0, 16'h0);
    chk("sat_drop_model", drop_cnt, exp_drop);
    chk("sat_drop_255", drop_cnt, 255);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
